// File: rtl/fetch_pipe_pkg.sv
// pipe_pkg: shared types and constants for the fetch stage.
//   fetch_state_e    : debug-halt FSM states
//   NOP_INST         : bubble instruction (addi x0,x0,0)
//   RESET_PC_DEFAULT : default fetch PC after reset
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    STEP
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pipe_if.sv
// fetch_pipe_if: pipeline/debug signals of the fetch stage.
//   master : hazard unit, instruction memory and debugger side
//   slave  : fetch_pipe side (drives pc_f, pc_x, ir_x, halted)
interface fetch_pipe_if;

  logic        stall;
  logic        flush;
  logic [31:0] br_target;
  logic [31:0] inst_in;
  logic [31:0] pc_f;
  logic [31:0] pc_x;
  logic [31:0] ir_x;
  logic        halt_req;
  logic        resume_req;
  logic        step_req;
  logic        dbg_pc_we;
  logic [31:0] dbg_pc_wdata;
  logic        halted;

  modport master (
    output stall, flush, br_target, inst_in,
    output halt_req, resume_req, step_req, dbg_pc_we, dbg_pc_wdata,
    input  pc_f, pc_x, ir_x, halted
  );

  modport slave (
    input  stall, flush, br_target, inst_in,
    input  halt_req, resume_req, step_req, dbg_pc_we, dbg_pc_wdata,
    output pc_f, pc_x, ir_x, halted
  );

endinterface

// File: rtl/fetch_pipe_dbg_halt_fsm.sv
// dbg_halt_fsm: debugger halt/resume/single-step control for the fetch stage.
//   clk, rst_n      : clock, async active-low reset
//   stall_i/flush_i : hazard unit decisions
//   halt_req_i, resume_req_i, step_req_i, dbg_pc_we_i : debugger controls
//   hold_fetch_o    : fetch PC does not advance this cycle
//   insert_nop_o    : load a bubble into EX
//   take_flush_o    : redirect fetch to br_target and bubble EX
//   dbg_pc_wr_o     : debugger PC write accepted
//   halted_o        : registered halted flag
module dbg_halt_fsm
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic flush_i,
  input  logic halt_req_i,
  input  logic resume_req_i,
  input  logic step_req_i,
  input  logic dbg_pc_we_i,
  output logic hold_fetch_o,
  output logic insert_nop_o,
  output logic take_flush_o,
  output logic dbg_pc_wr_o,
  output logic halted_o
);

  fetch_state_e state_q, state_d;
  logic         drain_after_step_q;
  logic         halted_q;
  logic         halt_accept;

  // Only the DRAIN that follows a single step has a real instruction in EX,
  // so only that one may redirect fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= RUN;
      drain_after_step_q <= 1'b0;
      halted_q           <= 1'b0;
    end else begin
      state_q            <= state_d;
      drain_after_step_q <= (state_q == STEP);
      halted_q           <= (state_d == HALTED);
    end
  end

  always_comb begin
    halt_accept = halt_req_i && !stall_i;
    state_d     = state_q;
    unique case (state_q)
      RUN:     if (halt_accept) state_d = DRAIN;
      DRAIN:   state_d = HALTED;
      HALTED:  begin
        if (resume_req_i)    state_d = RUN;
        else if (step_req_i) state_d = STEP;
      end
      STEP:    state_d = DRAIN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    hold_fetch_o = 1'b1;
    insert_nop_o = 1'b0;
    take_flush_o = 1'b0;
    dbg_pc_wr_o  = 1'b0;
    unique case (state_q)
      RUN: begin
        take_flush_o = flush_i;
        hold_fetch_o = flush_i || stall_i || halt_req_i;
        insert_nop_o = halt_req_i && !stall_i;
      end
      DRAIN: begin
        insert_nop_o = 1'b1;
        take_flush_o = flush_i && drain_after_step_q;
      end
      HALTED: begin
        insert_nop_o = 1'b1;
        dbg_pc_wr_o  = dbg_pc_we_i;
      end
      STEP:    hold_fetch_o = 1'b0;
      default: hold_fetch_o = 1'b1;
    endcase
  end

  assign halted_o = halted_q;

endmodule

// File: rtl/fetch_pipe.sv
// fetch_pipe: fetch PC plus IF->EX pipeline register with stall/flush and
// debugger halt/resume/single-step support.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_pipe_if.slave (hazard, imem and debugger signals;
//                outputs pc_f, pc_x, ir_x, halted)
module fetch_pipe
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INST
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_pipe_if.slave  bus
);

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_x_q, pc_x_d;
  logic [31:0] ir_x_q, ir_x_d;
  logic        hold_fetch;
  logic        insert_nop;
  logic        take_flush;
  logic        dbg_pc_wr;
  logic        halted;

  dbg_halt_fsm u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (bus.stall),
    .flush_i      (bus.flush),
    .halt_req_i   (bus.halt_req),
    .resume_req_i (bus.resume_req),
    .step_req_i   (bus.step_req),
    .dbg_pc_we_i  (bus.dbg_pc_we),
    .hold_fetch_o (hold_fetch),
    .insert_nop_o (insert_nop),
    .take_flush_o (take_flush),
    .dbg_pc_wr_o  (dbg_pc_wr),
    .halted_o     (halted)
  );

  always_comb begin
    pc_f_d = pc_f_q;
    pc_x_d = pc_x_q;
    ir_x_d = ir_x_q;
    if (take_flush) begin
      pc_f_d = bus.br_target;
      ir_x_d = NOP;
      pc_x_d = '0;
    end else if (!hold_fetch) begin
      pc_f_d = pc_f_q + 32'd4;
      ir_x_d = bus.inst_in;
      pc_x_d = pc_f_q;
    end else if (insert_nop) begin
      ir_x_d = NOP;
    end
    // Debugger write lands in pc_f now so the next RUN/STEP fetch uses it.
    if (dbg_pc_wr) pc_f_d = bus.dbg_pc_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_q <= RESET_PC;
      pc_x_q <= '0;
      ir_x_q <= NOP;
    end else begin
      pc_f_q <= pc_f_d;
      pc_x_q <= pc_x_d;
      ir_x_q <= ir_x_d;
    end
  end

  assign bus.pc_f   = pc_f_q;
  assign bus.pc_x   = pc_x_q;
  assign bus.ir_x   = ir_x_q;
  assign bus.halted = halted;

endmodule

// File: tb/tb_fetch_pipe.sv
module tb_fetch_pipe;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  typedef struct {
    logic        st, fl, ha, re, sp, we;
    logic [31:0] br, wd;
    logic [31:0] e_pcf, e_ir, e_pcx;
    bit          cx;
    logic        e_h;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] key;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[$];

  // Reference model state
  logic [31:0] m_pc, m_ir, m_pcx;
  bit          m_pcx_ok, m_from_step;
  string       m_mode;

  fetch_pipe_if bus ();

  fetch_pipe #(.RESET_PC(32'h0000_0000), .NOP(32'h0000_0013)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read, contents derived from address
  assign bus.inst_in = bus.pc_f ^ key;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, fl, input logic [31:0] br, input logic ha, re, sp, we,
                       input logic [31:0] wd);
    bus.stall = st; bus.flush = fl; bus.br_target = br;
    bus.halt_req = ha; bus.resume_req = re; bus.step_req = sp;
    bus.dbg_pc_we = we; bus.dbg_pc_wdata = wd;
  endtask

  task automatic clr();
    drive(0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic st, fl, input logic [31:0] br, input logic ha, re, sp, we,
                     input logic [31:0] wd, input logic [31:0] pcf, ir, pcx, input bit cx,
                     input logic h);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.ha = ha; v.re = re; v.sp = sp; v.we = we; v.wd = wd;
    v.e_pcf = pcf; v.e_ir = ir; v.e_pcx = pcx; v.cx = cx; v.e_h = h;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc_f", bus.pc_f, 32'h0);
    chk("reset_ir_x", bus.ir_x, TB_NOP);
    chk("reset_pc_x", bus.pc_x, 32'h0);
    chk("reset_halted", {31'b0, bus.halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_edge();
    logic [31:0] fetched;
    fetched = m_pc ^ key;
    if (m_mode == "RUN") begin
      if (bus.flush) begin
        m_pc = bus.br_target; m_ir = TB_NOP; m_pcx = '0; m_pcx_ok = 1;
        if (bus.halt_req && !bus.stall) begin m_mode = "DRAIN"; m_from_step = 0; end
      end else if (bus.stall) begin
      end else if (bus.halt_req) begin
        m_ir = TB_NOP; m_pcx_ok = 0; m_mode = "DRAIN"; m_from_step = 0;
      end else begin
        m_pcx = m_pc; m_ir = fetched; m_pc = m_pc + 32'd4; m_pcx_ok = 1;
      end
    end else if (m_mode == "DRAIN") begin
      m_ir = TB_NOP;
      if (m_from_step && bus.flush) begin m_pc = bus.br_target; m_pcx_ok = 0; end
      m_mode = "HALTED";
    end else if (m_mode == "HALTED") begin
      if (bus.dbg_pc_we) m_pc = bus.dbg_pc_wdata;
      if (bus.resume_req) m_mode = "RUN";
      else if (bus.step_req) m_mode = "STEP";
    end else begin
      m_pcx = m_pc; m_ir = fetched; m_pc = m_pc + 32'd4; m_pcx_ok = 1;
      m_mode = "DRAIN"; m_from_step = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    logic [31:0] r;
    key = '0;

    // ---------------- directed table (memory: inst = pc) ----------------
    //   st fl br       ha re sp we wd        pc_f     ir_x     pc_x    cx h
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h4,   32'h0,   32'h0,   1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h8,   32'h4,   32'h4,   1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'hC,   32'h8,   32'h8,   1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h10,  32'hC,   32'hC,   1, 0);
    add(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h10,  32'hC,   32'hC,   1, 0);
    add(1, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h10,  32'hC,   32'hC,   1, 0);
    add(1, 1, 32'h100, 0, 0, 0, 0, 32'h0,   32'h100, TB_NOP,  32'h0,   1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h104, 32'h100, 32'h100, 1, 0);
    add(0, 1, 32'h18,  0, 0, 0, 0, 32'h0,   32'h18,  TB_NOP,  32'h0,   1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h1C,  32'h18,  32'h18,  1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h20,  32'h1C,  32'h1C,  1, 0);
    add(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h20,  TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h20,  TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h20,  TB_NOP,  32'h0,   0, 1);
    add(1, 1, 32'h300, 0, 0, 0, 0, 32'h0,   32'h20,  TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h20,  TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h24,  32'h20,  32'h20,  1, 0);
    add(1, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h24,  32'h20,  32'h20,  1, 0);
    add(1, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h24,  32'h20,  32'h20,  1, 0);
    add(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h24,  TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h24,  TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h24,  TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h28,  32'h24,  32'h24,  1, 0);
    add(0, 1, 32'h80,  1, 0, 0, 0, 32'h0,   32'h80,  TB_NOP,  32'h0,   1, 0);
    add(0, 1, 32'h400, 0, 0, 0, 0, 32'h0,   32'h80,  TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 0, 0, 1, 32'h200, 32'h200, TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 0, 1, 0, 32'h0,   32'h200, TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h204, 32'h200, 32'h200, 1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h204, TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h204, TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h208, 32'h204, 32'h204, 1, 0);
    add(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h208, TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h208, TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 1, 1, 1, 32'h300, 32'h300, TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h304, 32'h300, 32'h300, 1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h308, 32'h304, 32'h304, 1, 0);
    add(0, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h308, TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h308, TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 0, 1, 1, 32'h500, 32'h500, TB_NOP,  32'h0,   0, 0);
    add(1, 0, 32'h0,   1, 0, 0, 0, 32'h0,   32'h504, 32'h500, 32'h500, 1, 0);
    add(0, 1, 32'h600, 0, 0, 0, 0, 32'h0,   32'h600, TB_NOP,  32'h0,   0, 1);
    add(0, 0, 32'h0,   0, 1, 0, 0, 32'h0,   32'h600, TB_NOP,  32'h0,   0, 0);
    add(0, 0, 32'h0,   0, 0, 0, 0, 32'h0,   32'h604, 32'h600, 32'h600, 1, 0);
    add(0, 0, 32'h0,   0, 0, 0, 1, 32'h700, 32'h608, 32'h604, 32'h604, 1, 0);

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].fl, tbl[i].br, tbl[i].ha, tbl[i].re, tbl[i].sp,
            tbl[i].we, tbl[i].wd);
      tick();
      chk($sformatf("vec%0d_pc_f", i), bus.pc_f, tbl[i].e_pcf);
      chk($sformatf("vec%0d_ir_x", i), bus.ir_x, tbl[i].e_ir);
      chk($sformatf("vec%0d_halted", i), {31'b0, bus.halted}, {31'b0, tbl[i].e_h});
      if (tbl[i].cx) chk($sformatf("vec%0d_pc_x", i), bus.pc_x, tbl[i].e_pcx);
    end
    clr();

    // ---------------- PC wrap ----------------
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, '0);
    tick();
    chk("wrap_redirect", bus.pc_f, 32'hFFFF_FFFC);
    clr();
    tick();
    chk("wrap_pc_f", bus.pc_f, 32'h0);
    chk("wrap_ir_x", bus.ir_x, 32'hFFFF_FFFC);
    chk("wrap_pc_x", bus.pc_x, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc_f2", bus.pc_f, 32'h4);
    chk("wrap_ir_x2", bus.ir_x, 32'h0);

    // ---------------- bounded halt latency ----------------
    bus.halt_req = 1'b1;
    cyc = 0;
    while (!bus.halted && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("halt_latency_cycles", cyc, 2);
    chk("halt_pc_held", bus.pc_f, 32'h4);
    bus.halt_req = 1'b0;
    bus.resume_req = 1'b1;
    tick();
    clr();
    chk("resume_halted", {31'b0, bus.halted}, 32'h0);

    // ---------------- reset during DRAIN ----------------
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drain_pc_f", bus.pc_f, 32'h0);
    chk("rst_drain_ir_x", bus.ir_x, TB_NOP);
    chk("rst_drain_halted", {31'b0, bus.halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_drain_run_pc_f", bus.pc_f, 32'h4);
    chk("rst_drain_run_ir_x", bus.ir_x, 32'h0);
    tick();
    chk("rst_drain_still_run", {31'b0, bus.halted}, 32'h0);

    // ---------------- randomized vs reference model ----------------
    key = 32'h1357_9BDF;
    do_reset();
    m_pc = '0; m_ir = TB_NOP; m_pcx = '0; m_pcx_ok = 1; m_from_step = 0; m_mode = "RUN";
    for (int n = 0; n < 600; n++) begin
      bus.stall      = ($urandom_range(0, 4) == 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      r = $urandom();
      bus.br_target  = r & 32'hFFFF_FFFC;
      bus.halt_req   = ($urandom_range(0, 11) == 0);
      bus.resume_req = ($urandom_range(0, 3) == 0);
      bus.step_req   = ($urandom_range(0, 4) == 0);
      bus.dbg_pc_we  = ($urandom_range(0, 2) == 0);
      r = $urandom();
      bus.dbg_pc_wdata = r & 32'hFFFF_FFFC;
      model_edge();
      tick();
      chk("rand_pc_f", bus.pc_f, m_pc);
      chk("rand_ir_x", bus.ir_x, m_ir);
      chk("rand_halted", {31'b0, bus.halted}, {31'b0, (m_mode == "HALTED")});
      if (m_pcx_ok) chk("rand_pc_x", bus.pc_x, m_pcx);
    end
    clr();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
